cmos_sync_align_ctrl: RTL
=========================

# cmos_sync_align_ctrl

Word-alignment and framing controller for the 4-data + 1-sync LVDS CMOS receiver. It watches the 20-bit sliding window of the sync channel, which shifts by 2 bits per `clk_input` cycle. It searches both bit offsets and all 5 cycle phases for the training word, confirms lock, then decodes sync-channel control words into `frame`, line and pixel qualifiers. The data-channel capture stage uses its `word_strobe` and `bit_offset` outputs to extract aligned 10-bit pixel words.

## Interface
Parameters:
- `TRAIN_WORD`, 10'h3A6: training pattern.
- `FS_WORD`, 10'h22A: frame start.
- `FE_WORD`, 10'h32A: frame end.
- `LS_WORD`, 10'h0AA: line start.
- `LE_WORD`, 10'h12A: line end.
- `IMG_WORD`, 10'h035: valid pixel word on the data channels.
- `LOCK_CNT`, 16: consecutive training hits required for lock, 2..255.
- `ERR_MAX`, 4: consecutive bad words that force relock, 1..15.

Ports:
- `clk_input` in 1: receiver word clock. All logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `align_en` in 1: enables search and lock. Low forces IDLE.
- `sync_window` in 20: sync-channel shift buffer. The newest 2 bits are in [1:0].
- `bit_offset` out 1: selected bit offset (0/1).
- `word_strobe` out 1: one-cycle pulse, once every 5 cycles while locked.
- `locked` out 1: alignment locked.
- `frame` out 1: frame active.
- `line_valid` out 1: line active.
- `pixel_valid` out 1: current strobed word is pixel data.
- `sync_error` out 1: one-cycle pulse per illegal sync word.
- `err_count` out 8: saturating total count of illegal words.
- `frame_count` out 16: count of FS words accepted. Wraps at 16'hFFFF→0.

## Operation
- Candidate word: `cand = bit_offset ? sync_window[10:1] : sync_window[9:0]`.
- Phase counter `ph` runs 0..4 and wraps. An "eval cycle" is a cycle where `ph==4`.
- FSM states: IDLE, SEARCH, CONFIRM, LOCKED.
- **IDLE**: all outputs except the counters are held 0. Move to SEARCH when `align_en=1`.
- **SEARCH**: checks every cycle.
  - If `sync_window[9:0]==TRAIN_WORD`: set `bit_offset=0`.
  - Otherwise, if `sync_window[10:1]==TRAIN_WORD`: set `bit_offset=1`.
  - Offset 0 wins if both match.
  - On a hit: `ph<=0`, `hits<=1`, go to CONFIRM.
- **CONFIRM**: on each eval cycle:
  - `cand==TRAIN_WORD`: `hits++`. When `hits` reaches `LOCK_CNT`, go to LOCKED.
  - Otherwise: `hits<=0`, go to SEARCH.
- **LOCKED**: on each eval cycle, decode `cand`. Any accepted word clears `cerr`.
  - TRAIN: legal only when `line_valid=0`.
  - FS: legal when `frame=0`. Sets `frame=1` and increments `frame_count`. FS while `frame=1` is an error, and `frame` stays 1 without an increment.
  - LS: legal when `frame=1` and `line_valid=0`. Sets `line_valid=1`.
  - IMG: legal when `line_valid=1`. `pixel_valid` pulses with the strobe.
  - LE: legal when `line_valid=1`. Clears `line_valid`.
  - FE: legal when `frame=1` and `line_valid=0`. Clears `frame`. FE with `line_valid=1` is an error and clears both.
  - Any other value, or any illegal case above, is an error:
    - pulse `sync_error`;
    - `err_count` increments, saturating at 255;
    - `cerr++`.
  - When `cerr` reaches `ERR_MAX`: go to SEARCH and clear `locked`, `frame` and `line_valid`.
- **Global rules**:
  - `align_en=0` in any state means go to IDLE on the next edge.
  - `err_count` and `frame_count` clear only on `rst_n`.
- Datapath contract: when `word_strobe=1`, the datapath takes the aligned word from each data buffer as bits [11+bit_offset : 2+bit_offset]. This compensates for the one-cycle registered strobe.

## Timing
- Reset value of every output is 0, and the FSM resets to IDLE.
- All outputs are registered. Decode results appear on the cycle after the eval cycle, coincident with `word_strobe`.
- Once locked, `word_strobe` has a period of exactly 5 cycles, with no gaps while LOCKED.
- `locked` rises the cycle after the `LOCK_CNT`-th matching eval cycle. The first `word_strobe` occurs 5 cycles later.
- `frame`, `line_valid`, `pixel_valid` and `sync_error` change only on strobe cycles, except when IDLE or relock clears them.
- Reset or `align_en` fall in mid-line clears all flags within 1 cycle. No partial `pixel_valid` is issued.

## Test plan
- Reset: assert `rst_n=0` with a random `sync_window` -> all outputs 0. After release with `align_en=0`, outputs stay 0.
- Offset-1 training: feed the 3A6 stream shifted by 1 bit -> `bit_offset=1`. `locked=1` one cycle after the 16th hit. `word_strobe` then pulses every 5 cycles.
- Frame sequence: after lock, feed TRAIN, FS, LS, IMG×4, LE, FE ->
  - `frame` is high from the FS strobe to the FE strobe;
  - `line_valid` covers the 4 IMG strobes;
  - 4 `pixel_valid` pulses;
  - `frame_count=1` and `err_count=0`.
- Error/relock: feed 4 words of 10'h000 while locked -> 4 `sync_error` pulses, `err_count=4`, `locked=0`, and the FSM returns to SEARCH. Feeding 3 garbage words then TRAIN keeps `locked=1`.
- Confirm failure: corrupt the 10th training word -> no lock, and the FSM returns to SEARCH.
- Mid-operation abort: drop `align_en` during IMG words -> the next cycle all flags are 0 and `frame_count` is retained. An `rst_n` pulse mid-frame zeroes everything asynchronously.

Source files
------------

// File: rtl/cmos_sync_align_ctrl.sv
// -----------------------------------------------------------------------------
// cmos_sync_align_ctrl
// Word-alignment and framing controller for a 4-data + 1-sync LVDS CMOS
// receiver. It hunts for the training word in the sync-channel sliding window
// at both bit offsets and all five cycle phases, confirms lock over LOCK_CNT
// consecutive training words, then decodes sync control words into frame,
// line and pixel qualifiers.
//
// Ports
//   clk_input    in   receiver word clock (rising edge)
//   rst_n        in   asynchronous active-low reset
//   align_en     in   enables search/lock; low forces IDLE
//   sync_window  in   20-bit sync shift buffer, newest 2 bits in [1:0]
//   bit_offset   out  selected bit offset (0/1)
//   word_strobe  out  one-cycle pulse every 5 cycles while locked
//   locked       out  alignment locked
//   frame        out  frame active
//   line_valid   out  line active
//   pixel_valid  out  strobed word is pixel data
//   sync_error   out  one-cycle pulse per illegal sync word
//   err_count    out  saturating count of illegal words
//   frame_count  out  count of accepted frame-start words (wraps)
// -----------------------------------------------------------------------------
module cmos_sync_align_ctrl #(
   parameter logic [9:0] TRAIN_WORD = 10'h3A6,
   parameter logic [9:0] FS_WORD    = 10'h22A,
   parameter logic [9:0] FE_WORD    = 10'h32A,
   parameter logic [9:0] LS_WORD    = 10'h0AA,
   parameter logic [9:0] LE_WORD    = 10'h12A,
   parameter logic [9:0] IMG_WORD   = 10'h035,
   parameter int         LOCK_CNT   = 16,
   parameter int         ERR_MAX    = 4
) (
   input  logic        clk_input,
   input  logic        rst_n,
   input  logic        align_en,
   input  logic [19:0] sync_window,
   output logic        bit_offset,
   output logic        word_strobe,
   output logic        locked,
   output logic        frame,
   output logic        line_valid,
   output logic        pixel_valid,
   output logic        sync_error,
   output logic [7:0]  err_count,
   output logic [15:0] frame_count
);

   typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_CONFIRM, ST_LOCKED} state_t;

   localparam logic [7:0] LOCK_CNT_W = 8'(LOCK_CNT);
   localparam logic [3:0] ERR_MAX_W  = 4'(ERR_MAX);

   state_t      state_q, state_d;
   logic [2:0]  ph_q, ph_d;
   logic [7:0]  hits_q, hits_d;
   logic [3:0]  cerr_q, cerr_d;
   logic        offset_q, offset_d;
   logic        strobe_q, strobe_d;
   logic        locked_q, locked_d;
   logic        frame_q, frame_d;
   logic        line_q, line_d;
   logic        pixel_q, pixel_d;
   logic        serr_q, serr_d;
   logic [7:0]  errc_q, errc_d;
   logic [15:0] fcnt_q, fcnt_d;

   logic [9:0]  cand;
   logic        eval;
   logic        legal;
   logic        unused_window;

   // Only the lower 11 bits of the window are ever inspected.
   assign unused_window = ^sync_window[19:11];

   assign cand = offset_q ? sync_window[10:1] : sync_window[9:0];
   assign eval = (ph_q == 3'd4);

   always_comb begin
      state_d  = state_q;
      ph_d     = eval ? 3'd0 : ph_q + 3'd1;
      hits_d   = hits_q;
      cerr_d   = cerr_q;
      offset_d = offset_q;
      strobe_d = 1'b0;
      locked_d = locked_q;
      frame_d  = frame_q;
      line_d   = line_q;
      pixel_d  = 1'b0;
      serr_d   = 1'b0;
      errc_d   = errc_q;
      fcnt_d   = fcnt_q;
      legal    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            offset_d = 1'b0;
            locked_d = 1'b0;
            frame_d  = 1'b0;
            line_d   = 1'b0;
            hits_d   = 8'd0;
            cerr_d   = 4'd0;
            state_d  = ST_SEARCH;
         end

         ST_SEARCH: begin
            locked_d = 1'b0;
            frame_d  = 1'b0;
            line_d   = 1'b0;
            // Offset 0 has priority when both alignments match.
            if (sync_window[9:0] == TRAIN_WORD) begin
               offset_d = 1'b0;
               ph_d     = 3'd0;
               hits_d   = 8'd1;
               state_d  = ST_CONFIRM;
            end else if (sync_window[10:1] == TRAIN_WORD) begin
               offset_d = 1'b1;
               ph_d     = 3'd0;
               hits_d   = 8'd1;
               state_d  = ST_CONFIRM;
            end
         end

         ST_CONFIRM: begin
            if (eval) begin
               if (cand == TRAIN_WORD) begin
                  hits_d = hits_q + 8'd1;
                  if (hits_q + 8'd1 == LOCK_CNT_W) begin
                     locked_d = 1'b1;
                     cerr_d   = 4'd0;
                     state_d  = ST_LOCKED;
                  end
               end else begin
                  hits_d  = 8'd0;
                  state_d = ST_SEARCH;
               end
            end
         end

         ST_LOCKED: begin
            if (eval) begin
               strobe_d = 1'b1;
               if (cand == TRAIN_WORD) begin
                  legal = !line_q;
               end else if (cand == FS_WORD) begin
                  if (!frame_q) begin
                     legal   = 1'b1;
                     frame_d = 1'b1;
                     fcnt_d  = fcnt_q + 16'd1;
                  end
               end else if (cand == LS_WORD) begin
                  if (frame_q && !line_q) begin
                     legal  = 1'b1;
                     line_d = 1'b1;
                  end
               end else if (cand == IMG_WORD) begin
                  if (line_q) begin
                     legal   = 1'b1;
                     pixel_d = 1'b1;
                  end
               end else if (cand == LE_WORD) begin
                  if (line_q) begin
                     legal  = 1'b1;
                     line_d = 1'b0;
                  end
               end else if (cand == FE_WORD) begin
                  // FE inside a line is illegal but still closes the frame.
                  if (line_q) begin
                     frame_d = 1'b0;
                     line_d  = 1'b0;
                  end else if (frame_q) begin
                     legal   = 1'b1;
                     frame_d = 1'b0;
                  end
               end

               if (legal) begin
                  cerr_d = 4'd0;
               end else begin
                  serr_d = 1'b1;
                  if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
                  cerr_d = cerr_q + 4'd1;
                  if (cerr_q + 4'd1 == ERR_MAX_W) begin
                     cerr_d   = 4'd0;
                     hits_d   = 8'd0;
                     locked_d = 1'b0;
                     frame_d  = 1'b0;
                     line_d   = 1'b0;
                     state_d  = ST_SEARCH;
                  end
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Disabling alignment overrides everything, including a pending decode.
      if (!align_en) begin
         state_d  = ST_IDLE;
         hits_d   = 8'd0;
         cerr_d   = 4'd0;
         offset_d = 1'b0;
         strobe_d = 1'b0;
         locked_d = 1'b0;
         frame_d  = 1'b0;
         line_d   = 1'b0;
         pixel_d  = 1'b0;
         serr_d   = 1'b0;
         errc_d   = errc_q;
         fcnt_d   = fcnt_q;
      end
   end

   always_ff @(posedge clk_input or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ph_q     <= 3'd0;
         hits_q   <= 8'd0;
         cerr_q   <= 4'd0;
         offset_q <= 1'b0;
         strobe_q <= 1'b0;
         locked_q <= 1'b0;
         frame_q  <= 1'b0;
         line_q   <= 1'b0;
         pixel_q  <= 1'b0;
         serr_q   <= 1'b0;
         errc_q   <= 8'd0;
         fcnt_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         ph_q     <= ph_d;
         hits_q   <= hits_d;
         cerr_q   <= cerr_d;
         offset_q <= offset_d;
         strobe_q <= strobe_d;
         locked_q <= locked_d;
         frame_q  <= frame_d;
         line_q   <= line_d;
         pixel_q  <= pixel_d;
         serr_q   <= serr_d;
         errc_q   <= errc_d;
         fcnt_q   <= fcnt_d;
      end
   end

   assign bit_offset  = offset_q;
   assign word_strobe = strobe_q;
   assign locked      = locked_q;
   assign frame       = frame_q;
   assign line_valid  = line_q;
   assign pixel_valid = pixel_q;
   assign sync_error  = serr_q;
   assign err_count   = errc_q;
   assign frame_count = fcnt_q;

endmodule
